// File: rtl/control_sequencer.sv
// Multi-cycle CPU control unit: fetch, decode on IR[31:27], per-class execute, back to fetch.
// Outputs are decoded from state and IR (only br T6 PCin follows CON_FF directly); memory reads stretch by MEM_WAIT cycles.
module control_sequencer #(
    parameter int MEM_WAIT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stop,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout,
    output logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
    output logic        Yin, Zin, ZLowOut, ZHighOut, HIin, HIout, LOin, LOout, Cout,
    output logic        R8in,
    output logic        InPortOut, OutPortIn, CONN_in,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic        clear
);
    typedef enum logic [3:0] {
        RESET_ST, T0, T1, T2, T3, T4, T5, T6, T7, PAUSE, HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_IMM, C_LD, C_LDI, C_ST, C_MUL, C_NEG, C_BR,
        C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT, C_NOP
    } cls_t;

    localparam logic [4:0] OP_ADD = 5'b00011;

    state_t     state, state_nxt, boundary;
    cls_t       cls;
    logic [4:0] opcode;
    logic [2:0] wait_cnt;
    logic       rst_hold, mem_done, last_step;
    logic       unused_ir_bits;

    assign opcode         = IR[31:27];
    assign unused_ir_bits = ^IR[26:0];
    assign mem_done       = (wait_cnt == 3'(MEM_WAIT));
    assign boundary       = stop ? PAUSE : T0;

    always_comb begin
        case (opcode)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8: cls = C_ALU;
            5'd9, 5'd10, 5'd11:                 cls = C_IMM;
            5'd0:                               cls = C_LD;
            5'd1:                               cls = C_LDI;
            5'd2:                               cls = C_ST;
            5'd12, 5'd13:                       cls = C_MUL;
            5'd14, 5'd15:                       cls = C_NEG;
            5'd16:                              cls = C_BR;
            5'd17:                              cls = C_JR;
            5'd18:                              cls = C_JAL;
            5'd19:                              cls = C_IN;
            5'd20:                              cls = C_OUT;
            5'd21:                              cls = C_MFHI;
            5'd22:                              cls = C_MFLO;
            5'd24:                              cls = C_HALT;
            default:                            cls = C_NOP;
        endcase
    end

    always_comb begin
        last_step = 1'b0;
        case (cls)
            C_ALU, C_IMM, C_LDI:               last_step = (state == T5);
            C_LD, C_ST:                        last_step = (state == T7);
            C_MUL, C_BR:                       last_step = (state == T6);
            C_NEG, C_JAL:                      last_step = (state == T4);
            C_JR, C_IN, C_OUT, C_MFHI, C_MFLO: last_step = (state == T3);
            default:                           last_step = (state == T2);
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RESET_ST: if (!rst_hold) state_nxt = boundary;
            T0:       state_nxt = T1;
            T1:       if (mem_done) state_nxt = T2;
            T2, T3, T4, T5, T6, T7: begin
                if (state == T2 && cls == C_HALT)
                    state_nxt = HALT;
                else if (state == T6 && cls == C_LD && !mem_done)
                    state_nxt = T6;
                else if (last_step)
                    state_nxt = boundary;
                else
                    state_nxt = state_t'(state + 4'd1);
            end
            PAUSE:    if (!stop) state_nxt = T0;
            default:  state_nxt = state;
        endcase
    end

    // rst_hold keeps RESET_ST (and clear) for one extra cycle after reset drops.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RESET_ST;
            rst_hold <= 1'b1;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            rst_hold <= 1'b0;
            if (state_nxt != state)
                wait_cnt <= 3'd0;
            else if (state == T1 || state == T6)
                wait_cnt <= wait_cnt + 3'd1;
        end
    end

    always_comb begin
        {Gra, Grb, Grc, Rin, Rout, BAout}                                   = '0;
        {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin}       = '0;
        {Yin, Zin, ZLowOut, ZHighOut, HIin, HIout, LOin, LOout, Cout}       = '0;
        {R8in, InPortOut, OutPortIn, CONN_in}                               = '0;
        alu_op = 5'd0;
        clear  = (state == RESET_ST);
        run    = !(state == RESET_ST || state == PAUSE || state == HALT);
        case (state)
            T0: {PCout, MARin, IncPC, Zin} = 4'b1111;
            T1: begin
                {ZLowOut, PCin, Read} = 3'b111;
                MDRin = mem_done;
            end
            T2: {MDRout, IRin} = 2'b11;
            T3: case (cls)
                C_ALU, C_IMM:      {Grb, Rout, Yin} = 3'b111;
                C_LD, C_LDI, C_ST: {Grb, BAout, Yin} = 3'b111;
                C_MUL:             {Gra, Rout, Yin} = 3'b111;
                C_NEG: begin
                    {Grb, Rout, Zin} = 3'b111;
                    alu_op = opcode;
                end
                C_BR:              {Gra, Rout, CONN_in} = 3'b111;
                C_JR:              {Gra, Rout, PCin} = 3'b111;
                C_JAL:             {PCout, R8in} = 2'b11;
                C_IN:              {InPortOut, Gra, Rin} = 3'b111;
                C_OUT:             {Gra, Rout, OutPortIn} = 3'b111;
                C_MFHI:            {HIout, Gra, Rin} = 3'b111;
                C_MFLO:            {LOout, Gra, Rin} = 3'b111;
                default: ;
            endcase
            T4: case (cls)
                C_ALU: begin
                    {Grc, Rout, Zin} = 3'b111;
                    alu_op = opcode;
                end
                C_IMM: begin
                    {Cout, Zin} = 2'b11;
                    alu_op = opcode;
                end
                C_LD, C_LDI, C_ST: begin
                    {Cout, Zin} = 2'b11;
                    alu_op = OP_ADD;
                end
                C_MUL: begin
                    {Grb, Rout, Zin} = 3'b111;
                    alu_op = opcode;
                end
                C_NEG:             {ZLowOut, Gra, Rin} = 3'b111;
                C_BR:              {PCout, Yin} = 2'b11;
                C_JAL:             {Gra, Rout, PCin} = 3'b111;
                default: ;
            endcase
            T5: case (cls)
                C_ALU, C_IMM, C_LDI: {ZLowOut, Gra, Rin} = 3'b111;
                C_LD, C_ST:          {ZLowOut, MARin} = 2'b11;
                C_MUL:               {ZLowOut, LOin} = 2'b11;
                C_BR: begin
                    {Cout, Zin} = 2'b11;
                    alu_op = OP_ADD;
                end
                default: ;
            endcase
            T6: case (cls)
                C_LD: begin
                    Read  = 1'b1;
                    MDRin = mem_done;
                end
                C_ST:  {Gra, Rout, MDRin} = 3'b111;
                C_MUL: {ZHighOut, HIin} = 2'b11;
                C_BR: begin
                    ZLowOut = 1'b1;
                    PCin    = CON_FF;
                end
                default: ;
            endcase
            T7: case (cls)
                C_LD:    {MDRout, Gra, Rin} = 3'b111;
                C_ST:    Write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (MEM_WAIT=0 and MEM_WAIT=2) checked cycle by cycle
// against a step-list model built directly from the per-opcode micro-step table.
module tb_control_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        stp [2];
    logic        con [2];
    logic [31:0] ir  [2];
    logic [34:0] obs [2];

    // Observation vector: [34]=clear [33]=run [32:28]=alu_op [27:0]=strobes
    localparam logic [27:0] GRA  = 28'd1 << 0,  GRB   = 28'd1 << 1,  GRC   = 28'd1 << 2,  RIN   = 28'd1 << 3;
    localparam logic [27:0] ROUT = 28'd1 << 4,  BAOUT = 28'd1 << 5,  PCOUT = 28'd1 << 6,  PCIN  = 28'd1 << 7;
    localparam logic [27:0] INC  = 28'd1 << 8,  MAR   = 28'd1 << 9,  MDRIN = 28'd1 << 10, MDROUT= 28'd1 << 11;
    localparam logic [27:0] RD   = 28'd1 << 12, WR    = 28'd1 << 13, IRIN  = 28'd1 << 14, YIN   = 28'd1 << 15;
    localparam logic [27:0] ZIN  = 28'd1 << 16, ZLO   = 28'd1 << 17, ZHI   = 28'd1 << 18, HIIN  = 28'd1 << 19;
    localparam logic [27:0] HIOUT= 28'd1 << 20, LOIN  = 28'd1 << 21, LOOUT = 28'd1 << 22, COUT  = 28'd1 << 23;
    localparam logic [27:0] R8IN = 28'd1 << 24, INP   = 28'd1 << 25, OUTP  = 28'd1 << 26, CONN  = 28'd1 << 27;
    localparam logic [34:0] ZERO = 35'd0;
    localparam logic [34:0] RSTV = 35'd1 << 34;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic gra, grb, grc, rin, rout, baout, pcout, pcin, incpc, marin, mdrin, mdrout, rd, wr, irin;
        logic yin, zin, zlo, zhi, hiin, hiout, loin, loout, cout, r8in, inp, outp, conn, run, clear;
        logic [4:0] alu_op;
        control_sequencer #(.MEM_WAIT(2 * g)) u_dut (
            .clock(clk), .reset(rst[g]), .stop(stp[g]), .IR(ir[g]), .CON_FF(con[g]),
            .Gra(gra), .Grb(grb), .Grc(grc), .Rin(rin), .Rout(rout), .BAout(baout),
            .PCout(pcout), .PCin(pcin), .IncPC(incpc), .MARin(marin), .MDRin(mdrin),
            .MDRout(mdrout), .Read(rd), .Write(wr), .IRin(irin),
            .Yin(yin), .Zin(zin), .ZLowOut(zlo), .ZHighOut(zhi), .HIin(hiin), .HIout(hiout),
            .LOin(loin), .LOout(loout), .Cout(cout), .R8in(r8in),
            .InPortOut(inp), .OutPortIn(outp), .CONN_in(conn),
            .alu_op(alu_op), .run(run), .clear(clear)
        );
        assign obs[g] = {clear, run, alu_op, conn, outp, inp, r8in, cout, loout, loin, hiout, hiin,
                         zhi, zlo, zin, yin, irin, wr, rd, mdrout, mdrin, marin, incpc, pcin,
                         pcout, baout, rout, rin, grc, grb, gra};
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cur      = -1;
    logic [34:0] exp_q[$];

    function automatic logic [34:0] v(input logic [27:0] m, input logic [4:0] a);
        return {1'b0, 1'b1, a, m};
    endfunction

    localparam logic [34:0] T0V = {1'b0, 1'b1, 5'd0, PCOUT | MAR | INC | ZIN};

    task automatic check(input logic [34:0] act, input logic [34:0] expv, input string name);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic check_int(input int act, input int expv, input string name);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic push(input logic [27:0] m, input logic [4:0] a);
        exp_q.push_back(v(m, a));
    endtask

    // Expected per-cycle outputs of one instruction, starting at T0.
    task automatic build(input logic [4:0] op, input int w, input logic c);
        exp_q.delete();
        push(PCOUT | MAR | INC | ZIN, 5'd0);
        for (int i = 0; i <= w; i++) push(ZLO | PCIN | RD | ((i == w) ? MDRIN : 28'd0), 5'd0);
        push(MDROUT | IRIN, 5'd0);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8: begin
                push(GRB | ROUT | YIN, 5'd0); push(GRC | ROUT | ZIN, op); push(ZLO | GRA | RIN, 5'd0);
            end
            5'd9, 5'd10, 5'd11: begin
                push(GRB | ROUT | YIN, 5'd0); push(COUT | ZIN, op); push(ZLO | GRA | RIN, 5'd0);
            end
            5'd0, 5'd1, 5'd2: begin
                push(GRB | BAOUT | YIN, 5'd0); push(COUT | ZIN, 5'd3);
                if (op == 5'd1) push(ZLO | GRA | RIN, 5'd0);
                else push(ZLO | MAR, 5'd0);
                if (op == 5'd0) begin
                    for (int i = 0; i <= w; i++) push(RD | ((i == w) ? MDRIN : 28'd0), 5'd0);
                    push(MDROUT | GRA | RIN, 5'd0);
                end else if (op == 5'd2) begin
                    push(GRA | ROUT | MDRIN, 5'd0); push(WR, 5'd0);
                end
            end
            5'd12, 5'd13: begin
                push(GRA | ROUT | YIN, 5'd0); push(GRB | ROUT | ZIN, op);
                push(ZLO | LOIN, 5'd0); push(ZHI | HIIN, 5'd0);
            end
            5'd14, 5'd15: begin
                push(GRB | ROUT | ZIN, op); push(ZLO | GRA | RIN, 5'd0);
            end
            5'd16: begin
                push(GRA | ROUT | CONN, 5'd0); push(PCOUT | YIN, 5'd0);
                push(COUT | ZIN, 5'd3); push(ZLO | (c ? PCIN : 28'd0), 5'd0);
            end
            5'd17: push(GRA | ROUT | PCIN, 5'd0);
            5'd18: begin push(PCOUT | R8IN, 5'd0); push(GRA | ROUT | PCIN, 5'd0); end
            5'd19: push(INP | GRA | RIN, 5'd0);
            5'd20: push(GRA | ROUT | OUTP, 5'd0);
            5'd21: push(HIOUT | GRA | RIN, 5'd0);
            5'd22: push(LOOUT | GRA | RIN, 5'd0);
            default: ;
        endcase
    endtask

    task automatic do_reset(input int k);
        rst[k] = 1'b1; stp[k] = 1'b0;
        @(negedge clk); check(obs[k], RSTV, $sformatf("reset%0d held", k));
        @(negedge clk); check(obs[k], RSTV, $sformatf("reset%0d held2", k));
        rst[k] = 1'b0;
        @(negedge clk); check(obs[k], RSTV, $sformatf("reset%0d release+1", k));
        @(negedge clk); check(obs[k], T0V, $sformatf("reset%0d first T0", k));
    endtask

    task automatic select(input int k);
        if (cur != k) begin
            if (cur >= 0) rst[cur] = 1'b1;
            do_reset(k);
            cur = k;
        end
    endtask

    // Entered with instance k showing T0; leaves it at T0 again.
    task automatic run_instr(input int k, input logic [4:0] op, input logic c, input int stop_at,
                             input int exp_len, input string tag);
        int n;
        int len;
        build(op, 2 * k, c);
        len = (exp_len < 0) ? exp_q.size() : exp_len;
        ir[k]  = {op, 27'($urandom)};
        con[k] = c;
        n = -1;
        for (int i = 0; i < 40; i++) begin
            if (i > 0 && (obs[k][33] == 1'b0 || obs[k] == T0V)) begin
                n = i;
                break;
            end
            if (i < exp_q.size()) check(obs[k], exp_q[i], $sformatf("%s step%0d", tag, i));
            else check(obs[k], T0V, $sformatf("%s overrun%0d", tag, i));
            if (i == stop_at) stp[k] = 1'b1;
            @(negedge clk);
        end
        check_int(n, len, {tag, " length"});
        if (op == 5'b11000) begin
            check(obs[k], ZERO, {tag, " halt entry"});
        end else if (stop_at >= 0) begin
            check(obs[k], ZERO, {tag, " pause"});
            @(negedge clk); check(obs[k], ZERO, {tag, " pause hold"});
            stp[k] = 1'b0;
            @(negedge clk); check(obs[k], T0V, {tag, " resume"});
        end else begin
            check(obs[k], T0V, {tag, " boundary"});
        end
    endtask

    typedef struct {
        logic [4:0] op;
        logic       c;
        int         k;
        int         stop_at;
        int         len;
    } vec_t;

    vec_t tbl[20];

    initial begin
        tbl[0]  = '{5'b00011, 1'b0, 0, -1, 6};
        tbl[1]  = '{5'b00011, 1'b0, 1, -1, 8};
        tbl[2]  = '{5'b00000, 1'b0, 1, -1, 12};
        tbl[3]  = '{5'b00000, 1'b0, 0, -1, 8};
        tbl[4]  = '{5'b00010, 1'b0, 1, -1, 10};
        tbl[5]  = '{5'b10000, 1'b1, 0, -1, 7};
        tbl[6]  = '{5'b10000, 1'b0, 1, -1, 9};
        tbl[7]  = '{5'b10001, 1'b0, 0, -1, 4};
        tbl[8]  = '{5'b10010, 1'b0, 1, -1, 7};
        tbl[9]  = '{5'b10111, 1'b0, 1, -1, 5};
        tbl[10] = '{5'b11111, 1'b0, 0, -1, 3};
        tbl[11] = '{5'b01100, 1'b0, 0, -1, 7};
        tbl[12] = '{5'b01110, 1'b0, 1, -1, 7};
        tbl[13] = '{5'b00001, 1'b0, 0, -1, 6};
        tbl[14] = '{5'b01001, 1'b0, 1, -1, 8};
        tbl[15] = '{5'b00011, 1'b0, 0, 4, 6};
        tbl[16] = '{5'b10110, 1'b0, 0, -1, 4};
        tbl[17] = '{5'b01101, 1'b0, 1, 2, 9};
        tbl[18] = '{5'b10100, 1'b0, 0, -1, 4};
        tbl[19] = '{5'b10011, 1'b0, 1, 1, 6};

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; stp[k] = 1'b0; con[k] = 1'b0; ir[k] = 32'd0;
        end
        @(negedge clk);

        for (int t = 0; t < 20; t++) begin
            select(tbl[t].k);
            run_instr(tbl[t].k, tbl[t].op, tbl[t].c, tbl[t].stop_at, tbl[t].len,
                      $sformatf("tbl%0d op%b", t, tbl[t].op));
        end

        // halt persists with stop toggling; only reset leaves it
        select(0);
        run_instr(0, 5'b11000, 1'b0, -1, 3, "halt");
        for (int i = 0; i < 20; i++) begin
            stp[0] = i[0];
            @(negedge clk);
            check(obs[0], ZERO, $sformatf("halt hold%0d", i));
        end
        stp[0] = 1'b0;
        do_reset(0);
        run_instr(0, 5'b00011, 1'b0, -1, 6, "post-halt add");

        // reset in the middle of ld T6 while Read is high
        select(1);
        build(5'b00000, 2, 1'b0);
        ir[1] = {5'b00000, 27'($urandom)};
        for (int i = 0; i <= 8; i++) begin
            check(obs[1], exp_q[i], $sformatf("ld-abort step%0d", i));
            if (i < 8) @(negedge clk);
        end
        check_int(int'(obs[1][12]), 1, "ld-abort Read before reset");
        do_reset(1);

        for (int t = 0; t < 150; t++) begin
            int         k;
            int         sa;
            logic [4:0] op;
            k  = int'($urandom_range(0, 1));
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11000) op = 5'b10111;
            sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            select(k);
            run_instr(k, op, 1'($urandom), sa, -1, $sformatf("rnd%0d op%b", t, op));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle control unit that drives every register and bus strobe consumed by the CPU datapath: register-file selects, PC, MAR/MDR, IR, Y/Z, HI/LO and I/O ports.
- Sequences fetch, then decode on IR[31:27], then a per-class execute sequence, then returns to fetch.
- Owns run/stop/halt handling and issues the datapath clear.

Parameters:
MEM_WAIT, 0, extra cycles Read is held before MDRin is pulsed (0..7).

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
stop  in  1  pause request, sampled only at instruction boundary (T0 entry)
IR  in  32  instruction register contents; opcode = IR[31:27]
CON_FF  in  1  branch-condition flip-flop from datapath
Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-file select/enable
PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin  out  1 each  fetch/memory strobes
Yin, Zin, ZLowOut, ZHighOut, HIin, HIout, LOin, LOout, Cout  out  1 each  ALU path strobes
R8in  out  1  return-address (R8) load, jal only
InPortOut, OutPortIn, CONN_in  out  1 each  I/O and branch-condition load
alu_op  out  5  ALU operation; opcode for ALU classes, 00011 (ADD) for address/branch math, 0 otherwise
run  out  1  1 while executing; 0 in RESET_ST, PAUSE, HALT
clear  out  1  datapath clear

Behaviour:
- Outputs are Moore: decoded from state, step and IR. The one exception is PCin in br T6, which is gated combinationally by CON_FF.
- Any strobe not listed for a step is 0. alu_op is 0 unless listed.
- Reset:
  - reset=1 forces state RESET_ST with clear=1, run=0 and all strobes 0. This applies mid-instruction too; partial sequences are abandoned.
  - The first cycle after reset falls holds RESET_ST (clear=1).
  - It then goes to T0, or to PAUSE if stop=1.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: ZLowOut, PCin, Read held for MEM_WAIT+1 cycles; MDRin only in the last of these cycles.
  - T2: MDRout, IRin.
- Execute, by opcode:
  - add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000:
    - T3 Grb,Rout,Yin
    - T4 Grc,Rout,Zin, alu_op=opcode
    - T5 ZLowOut,Gra,Rin
  - addi 01001, andi 01010, ori 01011: as above, but T4 uses Cout in place of Grc,Rout.
  - ld 00000:
    - T3 Grb,BAout,Yin
    - T4 Cout,Zin, alu_op=ADD
    - T5 ZLowOut,MARin
    - T6 Read held MEM_WAIT+1 cycles, MDRin in the last of them
    - T7 MDRout,Gra,Rin
  - ldi 00001: T3–T4 as ld; T5 ZLowOut,Gra,Rin.
  - st 00010: T3–T5 as ld; T6 Gra,Rout,MDRin (Read=0); T7 Write.
  - mul 01100, div 01101:
    - T3 Gra,Rout,Yin
    - T4 Grb,Rout,Zin, alu_op=opcode
    - T5 ZLowOut,LOin
    - T6 ZHighOut,HIin
  - neg 01110, not 01111: T3 Grb,Rout,Zin, alu_op=opcode; T4 ZLowOut,Gra,Rin.
  - br 10000:
    - T3 Gra,Rout,CONN_in
    - T4 PCout,Yin
    - T5 Cout,Zin, alu_op=ADD
    - T6 ZLowOut, with PCin=CON_FF
  - jr 10001: T3 Gra,Rout,PCin.
  - jal 10010: T3 PCout,R8in; T4 Gra,Rout,PCin.
  - in 10011: T3 InPortOut,Gra,Rin.
  - out 10100: T3 Gra,Rout,OutPortIn.
  - mfhi 10101: T3 HIout,Gra,Rin.
  - mflo 10110: T3 LOout,Gra,Rin.
  - nop 10111 and any undefined opcode: return to T0 after T2.
  - halt 11000: after T2 enter HALT.
- Instruction lengths in cycles, with W=MEM_WAIT:
  - ALU/imm: 6+W
  - ld: 8+2W
  - st: 8+W
  - br: 7+W
  - jr: 4+W
  - nop: 3+W
- Boundary:
  - On the last step of any instruction, the next state is T0, or PAUSE if stop=1.
  - PAUSE: run=0, all strobes 0. Return to T0 on the first cycle stop=0.
  - stop asserted mid-instruction has no effect until the boundary.
  - HALT: run=0, all strobes 0. Exits only via reset; stop is ignored.
  - The wait counter resets to 0 on every entry to T1/T6 and on reset.

Test Plan:
- reset held 2 cycles, then released with stop=0 -> clear=1 through release+1, run=0. T0 on the next cycle shows PCout=MARin=IncPC=Zin=1 and run=1.
- MEM_WAIT=0, IR=add (opcode 00011) -> 6-cycle sequence exactly as specified; T4 alu_op=00011; returns to T0 on cycle 7.
- MEM_WAIT=2, IR=ld (00000) -> Read high 3 cycles in T1 and 3 cycles in T6, MDRin only on the 3rd of each; total 12 cycles.
- IR=br (10000): with CON_FF=1 -> T6 PCin=1; with CON_FF=0 -> T6 PCin=0 and ZLowOut=1 in both cases.
- stop=1 raised during add T4 -> instruction completes, then PAUSE (run=0). stop=0 -> T0 next cycle. IR=halt (11000) -> HALT persists 20 cycles with stop toggling; only reset restores T0.
- reset asserted during ld T6 with Read=1 -> next cycle all strobes 0, clear=1, Read=0.
